// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/display memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BURST_LEN = 32;
    localparam int DEF_MAX_WAIT  = 4;

    // Starvation counter holds 0..MAX_WAIT, MAX_WAIT <= 15
    localparam int STARVE_W = 4;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_burst_gen.sv
// Display burst address generator: base pointer, words remaining, last flag.
module mem_arb_burst_gen
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    localparam int REM_W    = $clog2(BURST_LEN + 1)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_ptr,
    output logic [REM_W-1:0]  o_remaining,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_ptr;
    logic [REM_W-1:0]  r_remaining;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_ptr       <= i_base;
            r_remaining <= REM_W'(BURST_LEN);
        end else if (i_advance) begin
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - REM_W'(1);
        end
    end

    assign o_ptr       = r_ptr;
    assign o_remaining = r_remaining;
    assign o_last      = (r_remaining == REM_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// CPU-priority arbiter sharing one memory with a read-only display burst engine.
// Optional MEM_ARB_STATS_EN adds saturating stall/force counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int MAX_WAIT  = DEF_MAX_WAIT
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       force_cnt
`endif
);

    localparam int REM_W = $clog2(BURST_LEN + 1);

    arb_state_t          r_state;
    logic [STARVE_W-1:0] r_starve;
    logic                r_b_ack;
    logic                r_a_rvalid;
    logic                r_b_rvalid;
    logic                r_b_done;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_accept;
    logic                w_forced;
    logic                w_disp_slot;
    logic                w_cpu_slot;
    logic                w_cpu_read;
    logic [ADDR_W-1:0]   w_ptr;
    logic [REM_W-1:0]    w_remaining;
    logic                w_last;

    mem_arb_burst_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_burst_gen (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_base      (b_addr),
        .i_advance   (w_disp_slot),
        .o_ptr       (w_ptr),
        .o_remaining (w_remaining),
        .o_last      (w_last)
    );

    // Slot decision; everything is gated by reset so memory sees no access while held
    always_comb begin
        w_accept    = !reset && (r_state == IDLE) && b_req;
        w_forced    = (r_starve == STARVE_W'(MAX_WAIT));
        w_disp_slot = !reset && (r_state == BURST) && (w_remaining != '0)
                      && (!a_req || w_forced);
        w_cpu_slot  = !reset && a_req && !w_disp_slot;
        w_cpu_read  = w_cpu_slot && !a_we;
    end

    always_comb begin
        mem_address = '0;
        mem_load    = 1'b0;
        mem_wdata   = '0;
        if (w_cpu_slot) begin
            mem_address = a_addr;
            mem_load    = a_we;
            mem_wdata   = a_wdata;
        end else if (w_disp_slot) begin
            mem_address = w_ptr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_starve <= '0;
            r_b_ack  <= 1'b0;
        end else begin
            r_b_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= BURST;
                        r_starve <= '0;
                        r_b_ack  <= 1'b1;
                    end
                end
                BURST: begin
                    if (w_disp_slot) begin
                        r_starve <= '0;
                        if (w_last)
                            r_state <= IDLE;
                    end else if (w_cpu_slot) begin
                        r_starve <= r_starve + STARVE_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory returns data by the edge closing the slot; one shared capture register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_b_done   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_a_rvalid <= w_cpu_read;
            r_b_rvalid <= w_disp_slot;
            r_b_done   <= w_disp_slot && w_last;
            if (w_cpu_read || w_disp_slot)
                r_rdata <= mem_rdata;
        end
    end

    assign a_gnt    = w_cpu_slot;
    assign a_rvalid = r_a_rvalid;
    assign a_rdata  = r_rdata;
    assign b_ack    = r_b_ack;
    assign b_rvalid = r_b_rvalid;
    assign b_rdata  = r_rdata;
    assign b_done   = r_b_done;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_force_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_force_cnt <= '0;
        end else begin
            if (a_req && !w_cpu_slot)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_disp_slot && w_forced)
                r_force_cnt <= sat_inc(r_force_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign force_cnt = r_force_cnt;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the computer's single-port data memory between the CPU and a read-only display fetch engine. It sits between `cpu` and `memory`, and drives the memory's address, load and write-data inputs. The CPU has priority. A starvation counter guarantees the display engine forward progress during line-fetch bursts. Memory read latency is one cycle; the arbiter adds no address latency.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, memory word width
- `BURST_LEN`, 32, words per display burst (2..256)
- `MAX_WAIT`, 4, consecutive CPU-won cycles tolerated during a burst before display is forced (1..15)

Ports:
- `clk` in 1, system clock
- `reset` in 1, asynchronous, active-high
- `a_req` in 1, CPU requests access this cycle
- `a_we` in 1, CPU write (1) / read (0)
- `a_addr` in ADDR_W, CPU address
- `a_wdata` in DATA_W, CPU write data
- `a_gnt` out 1, CPU access performed this cycle; the CPU stalls while `a_req & !a_gnt`
- `a_rvalid` out 1, CPU read data valid
- `a_rdata` out DATA_W, CPU read data
- `b_req` in 1, display requests a burst (level)
- `b_addr` in ADDR_W, burst base address, sampled on accept
- `b_ack` out 1, one-cycle pulse: burst accepted
- `b_rvalid` out 1, burst word valid
- `b_rdata` out DATA_W, burst word
- `b_done` out 1, coincides with the last `b_rvalid` of a burst
- `mem_address` out ADDR_W, to memory
- `mem_load` out 1, memory write enable
- `mem_wdata` out DATA_W, memory write data
- `mem_rdata` in DATA_W, memory read data, one cycle after address

## Operation
- States:
  - IDLE: no burst in progress.
  - BURST: holds base pointer `ptr`, `remaining`, and `starve` (0..MAX_WAIT).
- IDLE with `b_req`:
  - Latch `ptr=b_addr` and `remaining=BURST_LEN`.
  - Pulse `b_ack` and go to BURST.
  - No display word is issued in the accept cycle. The CPU may still be granted in that cycle.
- Slot decision in BURST, evaluated each cycle:
  - If `!a_req` or `starve==MAX_WAIT`, issue a display read at `ptr`:
    - `ptr++`, wrapping mod 2^ADDR_W.
    - `remaining--`.
    - `starve=0`.
    - `a_gnt=0`.
  - Otherwise, grant the CPU and increment `starve`.
- When the last display word is issued, go to IDLE. A `b_req` still high is accepted in the following cycle.
- Outside BURST, `a_gnt = a_req`.
- `mem_*` are combinational from the slot winner:
  - CPU slot: `a_addr`, `a_we`, `a_wdata`.
  - Display slot: `ptr`, load 0.
  - No winner: `mem_load=0`, address 0.
- `b_req` is ignored while in BURST. The display port never writes.
- Read return: the data register captures `mem_rdata` one cycle after the slot.
  - CPU read slot: `a_rvalid=1`.
  - Display slot: `b_rvalid=1`.
  - `a_rdata` and `b_rdata` both carry the captured word.
- A CPU write gives `a_gnt=1` and no `a_rvalid`.

## Timing
- CPU read latency is 1 cycle after grant. Display word latency is 1 cycle after issue.
- Worst-case CPU stall: 1 cycle per MAX_WAIT+1 cycles inside a burst. Zero outside a burst.
- Asynchronous `reset`:
  - State is IDLE; `ptr`, `remaining` and `starve` are 0.
  - `a_rvalid`, `b_rvalid`, `b_ack` and `b_done` are 0; the data registers are 0.
  - Combinational outputs are forced low while `reset` is high: `a_gnt=0`, `mem_load=0`, `mem_address=0`.
- Reset mid-burst aborts the burst: no `b_done`, and any pending rvalid is dropped.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - Adds outputs `stall_cnt` [15:0] (cycles with `a_req & !a_gnt`) and `force_cnt` [15:0] (display slots forced by `starve==MAX_WAIT`).
  - Both are saturating and cleared by `reset`.
- Undefined: the ports and counters are absent, with no other behavioural difference.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, BURST).
  - default widths.
  - starvation counter width constant.
- Sub-module `mem_arb_burst_gen`:
  - Owns `ptr` and `remaining` (load, advance, last flag).
  - The top level owns the FSM, slot decision, starvation counter and read-return pipeline.

## Test plan
1. CPU only: write 0x1234 @0x0010, then read @0x0010 → `a_gnt=1` both cycles, `a_rvalid` one cycle after the read with 0x1234.
2. Display only, BURST_LEN=4, `b_addr=0x4000`:
   - `b_ack` pulse, then addresses 0x4000..0x4003 on consecutive cycles.
   - 4 `b_rvalid`, with `b_done` on the 4th.
3. Contention, MAX_WAIT=3, `a_req` held high through a burst → pattern CPU,CPU,CPU,display repeating; `a_gnt` low exactly on display slots.
4. Wrap: `b_addr=0xFFFE`, BURST_LEN=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. Reset asserted after 2 of 4 burst words →
   - Outputs are 0 immediately and no `b_done`.
   - After release, `b_req` starts a fresh burst from the new `b_addr`.
6. With `MEM_ARB_STATS_EN`, scenario 3 over 16 burst cycles → `stall_cnt=4`, `force_cnt=4`.
